// File: rtl/skew_buffer_ctrl.sv
// Input-skew stage for the systolic-array west edge: lane r is delayed r cycles, with valid/last
// tracking, stall, flush and an end-of-stream drain FSM. Optional build macro: SKEW_ZERO_GATE_EN.
module skew_buffer_ctrl #(
    parameter int unsigned ROW = 9,
    parameter int unsigned DW  = 9
) (
    input  logic              in_clk,
    input  logic              in_rst_n,
    input  logic              in_flush,
    input  logic              in_stall,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    input  logic [ROW*DW-1:0] in_data,
    output logic [ROW*DW-1:0] out_data,
    output logic [ROW-1:0]    out_valid,
    output logic              out_done,
    output logic              out_busy
);
    localparam int unsigned CW = (ROW > 1) ? $clog2(ROW) : 1;
    localparam int unsigned SD = (ROW > 1) ? ROW - 1 : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DRAIN
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic [SD-1:0] vld_q, vld_d;
    logic [SD-1:0] lst_q, lst_d;
    logic          accept;
    logic          advance;

    assign in_ready = ~in_stall & (state_q != S_DRAIN);
    assign accept   = in_valid & in_ready;
    assign advance  = ~in_stall;
    assign out_busy = busy_q;

    // Valid/last are identical for every lane: stage k holds the slot that entered k+1 advances ago.
    always_comb begin
        vld_d = vld_q;
        lst_d = lst_q;
        if (in_flush) begin
            vld_d = '0;
            lst_d = '0;
        end else if (advance) begin
            vld_d[0] = accept;
            lst_d[0] = accept & in_last;
            for (int unsigned k = 1; k < SD; k++) begin
                vld_d[k] = vld_q[k-1];
                lst_d[k] = lst_q[k-1];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (in_flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else if (advance) begin
            case (state_q)
                S_IDLE, S_STREAM: begin
                    if (accept) begin
                        cnt_d = '0;
                        if (!in_last)
                            state_d = S_STREAM;
                        else
                            state_d = (ROW > 1) ? S_DRAIN : S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (cnt_q == CW'(ROW - 2)) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            vld_q   <= '0;
            lst_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            vld_q   <= vld_d;
            lst_q   <= lst_d;
        end
    end

    // Lane 0 is a straight pass-through.
    assign out_valid[0] = accept;
`ifdef SKEW_ZERO_GATE_EN
    assign out_data[ROW*DW-1 -: DW] = accept ? in_data[ROW*DW-1 -: DW] : '0;
`else
    assign out_data[ROW*DW-1 -: DW] = in_data[ROW*DW-1 -: DW];
`endif

    for (genvar r = 1; r < ROW; r++) begin : g_lane
        logic [DW-1:0] dat_q [r];
        logic [DW-1:0] dat_d [r];
        logic [DW-1:0] slot_data;

`ifdef SKEW_ZERO_GATE_EN
        assign slot_data = accept ? in_data[(ROW-r)*DW-1 -: DW] : '0;
`else
        assign slot_data = in_data[(ROW-r)*DW-1 -: DW];
`endif

        always_comb begin
            for (int unsigned k = 0; k < r; k++) dat_d[k] = dat_q[k];
`ifdef SKEW_ZERO_GATE_EN
            if (in_flush) begin
                for (int unsigned k = 0; k < r; k++) dat_d[k] = '0;
            end else
`endif
            if (advance) begin
                dat_d[0] = slot_data;
                for (int unsigned k = 1; k < r; k++) dat_d[k] = dat_q[k-1];
            end
        end

        always_ff @(posedge in_clk) begin
            if (!in_rst_n) begin
                for (int unsigned k = 0; k < r; k++) dat_q[k] <= '0;
            end else begin
                for (int unsigned k = 0; k < r; k++) dat_q[k] <= dat_d[k];
            end
        end

        assign out_data[(ROW-r)*DW-1 -: DW] = dat_q[r-1];
        assign out_valid[r]                 = vld_q[r-1];
    end

    // Done must not repeat while the last slot is frozen under stall.
    if (ROW > 1) begin : g_done_reg
        assign out_done = lst_q[ROW-2] & vld_q[ROW-2] & ~in_stall & ~in_flush;
    end else begin : g_done_comb
        assign out_done = accept & in_last & ~in_flush;
    end

endmodule

// File: tb/tb_skew_buffer_ctrl.sv
// Randomised and directed bench for skew_buffer_ctrl (ROW=4, DW=9) against a vector-history
// reference model.
module tb_skew_buffer_ctrl;
    localparam int ROW = 4;
    localparam int DW  = 9;

    logic              in_clk = 1'b0;
    logic              in_rst_n;
    logic              in_flush;
    logic              in_stall;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic [ROW*DW-1:0] in_data;
    logic [ROW*DW-1:0] out_data;
    logic [ROW-1:0]    out_valid;
    logic              out_done;
    logic              out_busy;

    always #5 in_clk = ~in_clk;

    skew_buffer_ctrl #(.ROW(ROW), .DW(DW)) u_dut (
        .in_clk   (in_clk),
        .in_rst_n (in_rst_n),
        .in_flush (in_flush),
        .in_stall (in_stall),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_done (out_done),
        .out_busy (out_busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: history of whole input vectors (index 0 = most recent advance).
    logic              m_hv [ROW-1];
    logic              m_hl [ROW-1];
    logic [ROW*DW-1:0] m_hd [ROW-1];
    bit                m_stream;
    int                m_drain;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] lane(input logic [ROW*DW-1:0] vec, input int r);
        return vec[(ROW-r)*DW-1 -: DW];
    endfunction

    task automatic model_clear();
        for (int k = 0; k < ROW-1; k++) begin
            m_hv[k] = 1'b0;
            m_hl[k] = 1'b0;
            m_hd[k] = '0;
        end
        m_stream = 1'b0;
        m_drain  = 0;
    endtask

    task automatic cycle(input logic rst_n, input logic v, input logic l, input logic s,
                         input logic f, input logic [ROW*DW-1:0] d);
        logic           acc;
        logic           exp_rdy;
        logic [ROW-1:0] ev;
        in_rst_n = rst_n;
        in_valid = v;
        in_last  = l;
        in_stall = s;
        in_flush = f;
        in_data  = d;
        @(negedge in_clk);
        exp_rdy = !s && (m_drain == 0);
        acc     = v && exp_rdy;
        if (rst_n) begin
            ev[0] = acc;
            for (int r = 1; r < ROW; r++) ev[r] = m_hv[r-1];
            check_eq("ready", 64'(in_ready), 64'(exp_rdy));
            check_eq("valid", 64'(out_valid), 64'(ev));
            check_eq("busy", 64'(out_busy), 64'(m_stream || m_drain > 0));
            check_eq("done", 64'(out_done), 64'(m_hv[ROW-2] && m_hl[ROW-2] && !s && !f));
            if (acc) check_eq("lane0_data", 64'(lane(out_data, 0)), 64'(lane(d, 0)));
`ifdef SKEW_ZERO_GATE_EN
            else check_eq("lane0_zero", 64'(lane(out_data, 0)), 64'd0);
`endif
            for (int r = 1; r < ROW; r++) begin
                if (m_hv[r-1])
                    check_eq($sformatf("lane%0d_data", r), 64'(lane(out_data, r)),
                             64'(lane(m_hd[r-1], r)));
`ifdef SKEW_ZERO_GATE_EN
                else
                    check_eq($sformatf("lane%0d_zero", r), 64'(lane(out_data, r)), 64'd0);
`endif
            end
        end
        @(posedge in_clk);
        if (!rst_n || f) begin
            model_clear();
        end else if (!s) begin
            for (int k = ROW-2; k > 0; k--) begin
                m_hv[k] = m_hv[k-1];
                m_hl[k] = m_hl[k-1];
                m_hd[k] = m_hd[k-1];
            end
            m_hv[0] = acc;
            m_hl[0] = acc && l;
            m_hd[0] = d;
            if (m_drain > 0) begin
                m_drain--;
            end else if (acc) begin
                m_stream = !l;
                if (l) m_drain = ROW - 1;
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    logic [63:0] rnd;

    initial begin
        model_clear();
        in_rst_n = 1'b0;
        in_valid = 1'b1;
        in_last  = 1'b0;
        in_stall = 1'b0;
        in_flush = 1'b0;
        in_data  = '0;

        // Reset held two cycles with valid high
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, {9'd7, 9'd7, 9'd7, 9'd7});
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, {9'd7, 9'd7, 9'd7, 9'd7});
        idle(1);

        // Single-vector stream: skew and drain
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, {9'd1, 9'd2, 9'd3, 9'd4});
        idle(4);

        // Three-vector stream with a two-cycle stall after the second
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, {9'd11, 9'd12, 9'd13, 9'd14});
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, {9'd21, 9'd22, 9'd23, 9'd24});
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, {9'd99, 9'd99, 9'd99, 9'd99});
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, {9'd31, 9'd32, 9'd33, 9'd34});
        idle(5);

        // Bubble between vectors
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, {9'd41, 9'd42, 9'd43, 9'd44});
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, {9'd55, 9'd55, 9'd55, 9'd55});
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, {9'd61, 9'd62, 9'd63, 9'd64});
        idle(5);

        // Flush one cycle into drain, then a fresh stream
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, {9'd71, 9'd72, 9'd73, 9'd74});
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, '0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, {9'd81, 9'd82, 9'd83, 9'd84});
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, {9'd91, 9'd92, 9'd93, 9'd94});
        idle(5);

        // Stall during drain, flush during stall
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, {9'd101, 9'd102, 9'd103, 9'd104});
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, '0);
        idle(3);

        for (int i = 0; i < 3000; i++) begin
            rnd = {$urandom(), $urandom()};
            cycle($urandom_range(0, 199) != 0,
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 5) == 0,
                  $urandom_range(0, 39) == 0,
                  rnd[ROW*DW-1:0]);
        end
        idle(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
